// File: rtl/exe_muldiv_ctrl.sv
// Iterative signed multiply/divide sequencer beside the EXE-stage ALU.
// Radix-2 shift/add multiply and restoring divide on operand magnitudes, sign fixed up afterwards.
module exe_muldiv_ctrl #(
  parameter int WORD_LEN = 32,
  parameter int CNT_LEN  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] val1,
  input  logic [WORD_LEN-1:0] val2,
  input  logic                flush,
  output logic                stall,
  output logic                done,
  output logic [WORD_LEN-1:0] result,
  output logic                div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t state, state_next;

  logic [CNT_LEN-1:0]    cnt;
  logic [1:0]            op_q;
  logic                  sign_a, sign_b, b_zero;
  logic [WORD_LEN-1:0]   a_reg, b_reg, acc_hi, acc_lo;
  logic                  accept, last_iter;

  logic [WORD_LEN:0]     mul_sum;
  logic [WORD_LEN:0]     div_shift;
  logic                  div_ge;
  logic [WORD_LEN-1:0]   div_sub;
  logic [2*WORD_LEN-1:0] prod, prod_fix;
  logic [WORD_LEN-1:0]   quot_fix, rem_fix, sign_result;

  assign accept    = (state == IDLE) && start && !flush;
  assign last_iter = (cnt == CNT_LEN'(WORD_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_iter) state_next = SIGN;
      end
      SIGN: state_next = flush ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = accept || (state == CALC) || (state == SIGN);
    done  = (state == DONE) && !flush;
  end

  // Multiply: multiplier in a_reg shifts out LSB-first, product bits shift down into acc_lo.
  // Divide: dividend in a_reg shifts out MSB-first into the remainder (acc_hi), quotient builds in acc_lo.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (a_reg[0] ? b_reg : '0)};
    div_shift = {acc_hi, a_reg[WORD_LEN-1]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_sub   = div_shift[WORD_LEN-1:0] - b_reg;
  end

  // With a zero divisor the remainder path naturally reproduces |val1|, so REM needs no override.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (sign_a ^ sign_b) ? ((~prod) + (2*WORD_LEN)'(1)) : prod;
    quot_fix = (sign_a ^ sign_b) ? ((~acc_lo) + WORD_LEN'(1)) : acc_lo;
    rem_fix  = sign_a ? ((~acc_hi) + WORD_LEN'(1)) : acc_hi;
    case (op_q)
      2'b00:   sign_result = prod_fix[WORD_LEN-1:0];
      2'b01:   sign_result = prod_fix[2*WORD_LEN-1:WORD_LEN];
      2'b10:   sign_result = b_zero ? '1 : quot_fix;
      default: sign_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q        <= op;
          sign_a      <= val1[WORD_LEN-1];
          sign_b      <= val2[WORD_LEN-1];
          b_zero      <= (val2 == '0);
          a_reg       <= val1[WORD_LEN-1] ? ((~val1) + WORD_LEN'(1)) : val1;
          b_reg       <= val2[WORD_LEN-1] ? ((~val2) + WORD_LEN'(1)) : val2;
          acc_hi      <= '0;
          acc_lo      <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
        end
        CALC: begin
          cnt <= cnt + CNT_LEN'(1);
          if (op_q[1]) begin
            acc_hi <= div_ge ? div_sub : div_shift[WORD_LEN-1:0];
            acc_lo <= {acc_lo[WORD_LEN-2:0], div_ge};
            a_reg  <= {a_reg[WORD_LEN-2:0], 1'b0};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WORD_LEN-1:1]};
            a_reg            <= {1'b0, a_reg[WORD_LEN-1:1]};
          end
        end
        SIGN: if (!flush) begin
          result      <= sign_result;
          div_by_zero <= op_q[1] && b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule
